// File: rtl/fc_argmax.sv
`default_nettype none
// ============================================================================
// Module   : fc_argmax
// Purpose  : Arg-max classification stage behind the fully-connected layer.
//            On start, snapshots no_input IEEE-754 binary32 scores, scans
//            them one per clock and reports the index and bit-exact value of
//            the largest non-NaN score together with a one-cycle done pulse.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   DATA_WIDTH  score width, binary32 only (must be 32)
//   no_input    number of scores / classes, 2..128
//   IDX_WIDTH   class index width, 2**IDX_WIDTH >= no_input
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   start      in   single-cycle request, honoured only while idle
//   scores_in  in   flattened scores, score i at [i*DATA_WIDTH +: DATA_WIDTH]
//   busy       out  high while a scan (including its finish cycle) is running
//   done       out  one-cycle pulse, results valid
//   class_idx  out  index of the maximum score
//   max_value  out  maximum score, copied bit-exact from the winning input
//   valid      out  1 if at least one non-NaN score was seen
// ============================================================================
module fc_argmax #(
   parameter int DATA_WIDTH = 32,
   parameter int no_input   = 10,
   parameter int IDX_WIDTH  = 7
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           start,
   input  logic [DATA_WIDTH*no_input-1:0] scores_in,
   output logic                           busy,
   output logic                           done,
   output logic [IDX_WIDTH-1:0]           class_idx,
   output logic [DATA_WIDTH-1:0]          max_value,
   output logic                           valid
);

   // -------------------------------------------------------------------------
   // Elaboration-time parameter legality
   // -------------------------------------------------------------------------
   if (DATA_WIDTH != 32) begin : g_bad_data_width
      $error("fc_argmax: DATA_WIDTH must be 32 (binary32 scores)");
   end
   if (no_input < 2 || no_input > 128) begin : g_bad_no_input
      $error("fc_argmax: no_input must be in 2..128");
   end
   if ((2 ** IDX_WIDTH) < no_input) begin : g_bad_idx_width
      $error("fc_argmax: IDX_WIDTH too small for no_input");
   end

   localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(no_input - 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SCAN   = 2'd1,
      FINISH = 2'd2
   } state_t;

   // -------------------------------------------------------------------------
   // binary32 helpers
   // -------------------------------------------------------------------------
   // NaN: all-ones exponent with a nonzero mantissa (Inf has a zero mantissa).
   function automatic logic is_nan(input logic [DATA_WIDTH-1:0] v);
      return (v[30:23] == 8'hFF) && (v[22:0] != 23'd0);
   endfunction

   // Strict "a > b" for two non-NaN binary32 values using sign-magnitude
   // ordering. Zeros are folded to a non-negative zero so that +0 == -0;
   // denormals and infinities fall out of the raw magnitude compare.
   function automatic logic is_greater(input logic [DATA_WIDTH-1:0] a,
                                       input logic [DATA_WIDTH-1:0] b);
      logic a_zero;
      logic b_zero;
      logic a_neg;
      logic b_neg;
      a_zero = (a[30:0] == 31'd0);
      b_zero = (b[30:0] == 31'd0);
      a_neg  = a[31] & ~a_zero;
      b_neg  = b[31] & ~b_zero;
      if (a_neg != b_neg) begin
         return b_neg;                 // the non-negative one is larger
      end else if (!a_neg) begin
         return a[30:0] > b[30:0];     // both non-negative: bigger magnitude
      end else begin
         return a[30:0] < b[30:0];     // both negative: smaller magnitude
      end
   endfunction

   // -------------------------------------------------------------------------
   // State
   // -------------------------------------------------------------------------
   state_t                         state;
   logic [DATA_WIDTH*no_input-1:0] snapshot;
   logic [IDX_WIDTH-1:0]           idx;
   logic [IDX_WIDTH-1:0]           best_idx;
   logic [DATA_WIDTH-1:0]          best_val;
   logic                           have_best;

   logic [DATA_WIDTH-1:0]          cur_score;
   logic                           take_cur;

   // Select snapshot[idx]. A constant-index loop keeps every part-select
   // static, so the mux is built without any out-of-range slicing.
   always_comb begin
      cur_score = '0;
      for (int i = 0; i < no_input; i++) begin
         if (idx == IDX_WIDTH'(i)) begin
            cur_score = snapshot[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   // A non-NaN score becomes the best either because nothing has been kept
   // yet or because it is strictly greater. Ties keep the earlier index.
   always_comb begin
      take_cur = 1'b0;
      if (!is_nan(cur_score)) begin
         take_cur = !have_best || is_greater(cur_score, best_val);
      end
   end

   // -------------------------------------------------------------------------
   // Control FSM with registered outputs
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         snapshot  <= '0;
         idx       <= '0;
         best_idx  <= '0;
         best_val  <= '0;
         have_best <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         class_idx <= '0;
         max_value <= '0;
         valid     <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  snapshot  <= scores_in;
                  idx       <= '0;
                  best_idx  <= '0;
                  best_val  <= '0;
                  have_best <= 1'b0;
                  busy      <= 1'b1;
                  state     <= SCAN;
               end
            end

            SCAN: begin
               if (take_cur) begin
                  best_val  <= cur_score;
                  best_idx  <= idx;
                  have_best <= 1'b1;
               end
               if (idx == LAST_IDX) begin
                  idx   <= '0;
                  state <= FINISH;
               end else begin
                  idx <= idx + 1'b1;
               end
            end

            FINISH: begin
               // Result registers only move here, so they hold steady
               // through any following scan.
               if (have_best) begin
                  class_idx <= best_idx;
                  max_value <= best_val;
                  valid     <= 1'b1;
               end else begin
                  class_idx <= '0;
                  max_value <= snapshot[DATA_WIDTH-1:0];
                  valid     <= 1'b0;
               end
               done  <= 1'b1;
               busy  <= 1'b0;
               state <= IDLE;
            end

            default: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: doc/fc_argmax.md
# fc_argmax

Classification stage that sits directly downstream of the fully-connected layer. On `start` it snapshots the FC layer's `no_input` IEEE-754 binary32 scores and scans them one per clock. It reports the index and value of the largest score, with a one-cycle `done` pulse. Its `start` is driven by the FC layer's `done`.

## Interface
- `DATA_WIDTH`, 32, score width; the binary32 format is required, so only 32 is legal.
- `no_input`, 10, number of FC scores (classes); legal range 2..128.
- `IDX_WIDTH`, 7, width of the class index; must satisfy 2^IDX_WIDTH >= `no_input`.

Ports:
- `clk`  in  1  single clock, all state on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  single-cycle request; sampled only in IDLE.
- `scores_in`  in  `DATA_WIDTH*no_input`  flattened scores; score i at bits [i*DATA_WIDTH +: DATA_WIDTH].
- `busy`  out  1  high in SCAN and FINISH.
- `done`  out  1  one-cycle pulse when results are valid.
- `class_idx`  out  `IDX_WIDTH`  index of the maximum score.
- `max_value`  out  `DATA_WIDTH`  maximum score, bit-exact copy of the winning input.
- `valid`  out  1  1 if at least one non-NaN score was seen; 0 means all inputs were NaN.

## Operation
- States:
  - IDLE: `start`=1 captures `scores_in` into an internal snapshot register, sets idx=0, clears the running best, sets the have_best flag to 0, and goes to SCAN.
  - SCAN: compares snapshot[idx] against the running best, then idx++. After idx=`no_input`-1 is processed, goes to FINISH.
  - FINISH: updates `class_idx`, `max_value` and `valid` from the running best, asserts `done`, and returns to IDLE.
- Compare rules for binary32:
  - NaN is any score with exponent 0xFF and nonzero mantissa. NaN is never taken as best.
  - The first non-NaN score is taken unconditionally and sets have_best.
  - Later scores replace the best only if strictly greater, using sign-magnitude ordering: positive > negative; among positives the larger magnitude wins; among negatives the smaller magnitude wins.
  - +0 and -0 compare equal. ±Inf obey normal ordering. Denormals are compared by raw magnitude, with no flushing.
  - Ties are never strictly greater, so the lowest index wins.
- If all scores are NaN:
  - `valid`=0, `class_idx`=0, `max_value`=snapshot[0].
- Result outputs hold their values until the next FINISH. They do not change during a new SCAN.
- `scores_in` may change freely after the `start` edge. Only the snapshot is used.
- `start` is ignored while `busy`=1 (no queueing).
- `rst_n` low at any time, including mid-SCAN:
  - State is forced to IDLE, idx=0 and have_best=0.
  - Outputs are cleared: `busy`=0, `done`=0, `class_idx`=0, `max_value`=0, `valid`=0.
  - The in-flight scan is discarded, with no `done` pulse.

## Timing
- Reset values: every output is 0.
- Start is sampled at edge E0, after which `busy`=1.
- SCAN processes index k on edge E(k+1), for k=0..`no_input`-1.
- FINISH occupies the cycle after edge E(`no_input`). Results and `done` are registered at edge E(`no_input`+1), so `done`=1 during the cycle following that edge.
- The `done` pulse lasts exactly one cycle. The state is IDLE in the same cycle.
- Latency from the `start` edge to `done` high: `no_input`+1 cycles.
- A new `start` is accepted in the cycle `done` is high. Back-to-back throughput is one result per `no_input`+2 cycles.
- `busy` deasserts in the same cycle `done` asserts.

## Test plan
- Reset: hold `rst_n`=0 with `start`=1 -> all outputs 0, no `done`. After release with `start`=0 -> remains idle.
- Basic, `no_input`=4, scores {0x3F800000 (1.0), 0x40000000 (2.0), 0xBF800000 (-1.0), 0x3FC00000 (1.5)}:
  - `done` after exactly 5 cycles, `class_idx`=1, `max_value`=0x40000000, `valid`=1.
  - Change `scores_in` the cycle after `start` -> same result.
- Negatives, ties and signed zero:
  - {0xC0000000 (-2.0), 0xBF800000 (-1.0), 0xBF800000, 0xC0400000 (-3.0)} -> idx 1.
  - {0x80000000 (-0), 0x00000000 (+0), 0xBF800000, 0xBF800000} -> idx 0, `max_value`=0x80000000.
- NaN and Inf:
  - {0x7FC00000 (NaN), 0xFF800000 (-Inf), 0x7F800000 (+Inf), 0x7FC00000} -> idx 2, `max_value`=0x7F800000, `valid`=1.
  - All four scores 0x7FC00000 -> `valid`=0, `class_idx`=0.
- Start while busy, then reset mid-scan:
  - Pulse `start` again during SCAN -> ignored, exactly one `done`.
  - Assert `rst_n`=0 at SCAN idx=2 -> outputs cleared, no `done`.
  - Restart -> correct result after 5 cycles.
- Back-to-back: assert `start` in the same cycle `done` is high, with new scores -> second `done` exactly 6 cycles later, carrying the second set's result.
